async_fifo_rd_ctrl: RTL
=======================

# async_fifo_rd_ctrl

Read-side pointer controller for the asynchronous FIFO; the counterpart of the write-side Gray pointer generator. It runs entirely in the read clock domain. It synchronises the incoming Gray-coded write pointer, decodes it to binary, and maintains the local read pointer in both binary and Gray form. From these it produces the RAM read address, the empty flag, the fill level and the read handshake. Its Gray read pointer is exported to the write domain for full detection.

## Interface
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit)
- SYNC_STAGES, 2, flip-flop stages on the incoming write pointer (legal: 2 or 3)

- clk  in  1  read-domain clock; all logic on rising edge
- clear  in  1  synchronous, active-high reset
- wptr_gray_async  in  ADDR_W+1  Gray write pointer from the write domain (asynchronous to clk)
- rd_en  in  1  read request
- rd_addr  out  ADDR_W  RAM read address = rptr_bin[ADDR_W-1:0]
- rd_valid  out  1  one-cycle pulse: RAM data for the accepted read is valid this cycle
- rptr_gray  out  ADDR_W+1  registered Gray read pointer, to write-domain synchroniser
- empty  out  1  FIFO empty as seen in read domain
- level  out  ADDR_W+1  entries available, 0..2^ADDR_W
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Synchroniser: wptr_gray_async passes through SYNC_STAGES flops; the last stage is wsync_gray. Only wsync_gray is used downstream.
- Decode: wsync_bin = gray2bin(wsync_gray), computed combinationally from flops.
- Read pointer: rptr_bin and rptr_gray are registered together. On accept, rptr_bin <= rptr_bin+1 (mod 2^(ADDR_W+1)) and rptr_gray <= bin2gray(rptr_bin+1). Exactly one rptr_gray bit changes per accept.
- Accept: rd_en && !empty at a rising edge. The RAM registers data at the same edge from rd_addr.
- rd_valid <= accept.
- underflow <= rd_en && empty; the pointer does not move.
- empty = (rptr_gray == wsync_gray), a function of flops only.
- level = wsync_bin - rptr_bin, mod 2^(ADDR_W+1).
- Full as seen here (level = 2^ADDR_W) is legal. It is not flagged; full detection belongs to the write side.
- Clear: all pointers and synchroniser stages go to 0, giving empty=1, level=0, rd_addr=0, rptr_gray=0, rd_valid=0, underflow=0. Clear overrides rd_en in the same cycle. The write side must be cleared in the same reset window; this is a system-level requirement, not checked here.

## Timing
- Write-pointer latency: a change on wptr_gray_async that is stable before edge N is reflected in wsync_gray, empty and level after edge N+SYNC_STAGES-1.
- Read latency: accept at edge N, then rd_valid high during cycle N..N+1. Reads can be accepted back-to-back every cycle.
- The last entry read at edge N gives empty=1 after edge N. A further rd_en at edge N+1 gives underflow=1 and no rd_valid.
- A simultaneous write-pointer update and read is safe. level is pessimistic (under-reports) by at most the synchroniser latency.
- Wrap-around: rd_addr goes 2^ADDR_W-1 → 0. The wrap bit distinguishes empty from full.

## Structure
- Shared package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width
  - default ADDR_W
- Sub-module ptr_sync: an SYNC_STAGES-deep, (ADDR_W+1)-bit synchroniser with clear. The write side reuses it for rptr_gray.
- Everything else is flat in async_fifo_rd_ctrl.

## Test plan
All tests use ADDR_W=2 (3-bit pointers; Gray sequence 000,001,011,010,110,111,101,100) and SYNC_STAGES=2.
- **Reset:** hold clear 3 cycles with wptr_gray_async=110 and rd_en=1. Required: empty=1, level=0, rd_addr=0, rptr_gray=000, rd_valid=0, underflow=0 throughout.
- **Sync latency:** after clear, drive wptr 000→001 before edge N. Required: empty=1 through edge N; empty=0 and level=1 after edge N+1.
- **Drain:** wptr=110 (4 entries), rd_en high for 6 cycles. Required:
  - rd_addr 0,1,2,3, then 0
  - rd_valid pulses 4 times
  - rptr_gray ends at 110
  - empty=1 after 4th accept
  - underflow pulses on cycles 5 and 6
- **Full/wrap:** step wptr through all 8 codes interleaved with reads. Required: level never exceeds 4, level=4 reported when wptr leads by 4, rd_addr wraps 3→0, rptr_gray changes by exactly one bit per accept.
- **Clear mid-operation:** with level=3 and rd_en=1, assert clear for 1 cycle. Required: after that edge, all outputs are at their reset values and no rd_valid occurs for that edge.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO: Gray/binary conversion
// and the default RAM address width.
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_W = 4;

   // Conversions run on a wide vector; callers zero-extend in and truncate out,
   // which is exact because leading zeros never change the low Gray/binary bits.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-stage flop synchroniser for a Gray-coded FIFO pointer crossing clock domains.
// Also used by the write side to bring the read pointer across.
module ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   // The first stage may go metastable; only the last stage is consumed downstream.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer controller of the asynchronous FIFO: synchronises the write
// pointer, tracks the read pointer, and derives empty, level and read handshake.
module async_fifo_rd_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [ADDR_W:0]   wptr_gray_async,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [ADDR_W:0]   rptr_gray,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              underflow
);

   localparam int PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0] w_wsync_gray;
   logic [PTR_W-1:0] w_wsync_bin;
   logic [PTR_W-1:0] w_rptr_bin_nxt;
   logic [PTR_W-1:0] r_rptr_bin;
   logic [PTR_W-1:0] r_rptr_gray;
   logic             r_rd_valid;
   logic             r_underflow;
   logic             w_empty;
   logic             w_accept;

   ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk   (clk),
      .clear (clear),
      .i_d   (wptr_gray_async),
      .o_q   (w_wsync_gray)
   );

   assign w_wsync_bin    = PTR_W'(gray2bin(GRAY_MAX_W'(w_wsync_gray)));
   assign w_rptr_bin_nxt = r_rptr_bin + PTR_W'(1);

   // Empty compares registered Gray values directly, so it is glitch-free and
   // includes the wrap bit, which is what separates empty from full.
   assign w_empty  = (r_rptr_gray == w_wsync_gray);
   assign w_accept = rd_en && !w_empty;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_rptr_bin  <= '0;
         r_rptr_gray <= '0;
         r_rd_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rptr_bin  <= w_rptr_bin_nxt;
            r_rptr_gray <= PTR_W'(bin2gray(GRAY_MAX_W'(w_rptr_bin_nxt)));
         end
         r_rd_valid  <= w_accept;
         r_underflow <= rd_en && w_empty;
      end
   end

   assign rd_addr   = r_rptr_bin[ADDR_W-1:0];
   assign rd_valid  = r_rd_valid;
   assign rptr_gray = r_rptr_gray;
   assign empty     = w_empty;
   assign level     = w_wsync_bin - r_rptr_bin;
   assign underflow = r_underflow;

endmodule
